// File: rtl/fpcvt_arb.sv
// Four-way round-robin arbiter feeding a shared 13-bit linear to sign/exp/significand
// converter, with a single registered output stage and a saturating transfer counter.
module fpcvt_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [51:0] req_data,
  output logic [3:0]  req_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_id,
  output logic        out_s,
  output logic [2:0]  out_e,
  output logic [4:0]  out_f,
  output logic [15:0] conv_count
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  out_id_q, out_id_d;
  logic        out_s_q, out_s_d;
  logic [2:0]  out_e_q, out_e_d;
  logic [4:0]  out_f_q, out_f_d;
  logic [15:0] cnt_q, cnt_d;

  logic        accept_s;
  logic        grant_s;
  logic        xfer_s;
  logic [7:0]  rot2_s;
  logic [1:0]  offset_s;
  logic [1:0]  gnt_idx_s;
  logic [12:0] sample_s;
  logic [8:0]  cvt_s;

  // Returns {sign, exponent[2:0], significand[4:0]}; rounds half-up on the bit below
  // the 5-bit window and saturates to the largest code when rounding overflows E=7.
  function automatic logic [8:0] fp_convert(input logic [12:0] d);
    logic [12:0] mag13;
    logic [11:0] mag;
    logic [3:0]  p;
    logic        found;
    logic [5:0]  sh;
    logic [2:0]  e;
    logic [4:0]  f;
    logic        rnd;
    logic [5:0]  f_inc;
    mag13 = d[12] ? (~d + 13'd1) : d;
    mag   = mag13[12] ? 12'hFFF : mag13[11:0];
    p     = 4'd0;
    found = 1'b0;
    for (int i = 11; i >= 5; i--) begin
      if (!found && mag[i]) begin
        p     = 4'(i);
        found = 1'b1;
      end
    end
    if (found) begin
      sh  = 6'(mag >> (p - 4'd5));
      f   = sh[5:1];
      rnd = sh[0];
      e   = 3'(p - 4'd4);
    end else begin
      sh  = 6'd0;
      f   = mag[4:0];
      rnd = 1'b0;
      e   = 3'd0;
    end
    f_inc = {1'b0, f} + {5'd0, rnd};
    if (f_inc[5]) begin
      if (e == 3'd7) begin
        f = 5'h1F;
      end else begin
        e = e + 3'd1;
        f = 5'h10;
      end
    end else begin
      f = f_inc[4:0];
    end
    return {d[12], e, f};
  endfunction

  assign out_valid  = (state_q == ST_FULL);
  assign out_id     = out_id_q;
  assign out_s      = out_s_q;
  assign out_e      = out_e_q;
  assign out_f      = out_f_q;
  assign conv_count = cnt_q;

  // Rotated priority search starting at ptr; nothing is granted during reset.
  always_comb begin
    accept_s = ~out_valid | out_ready;
    xfer_s   = out_valid & out_ready;
    rot2_s   = {req_valid, req_valid} >> ptr_q;
    if (rot2_s[0]) begin
      offset_s = 2'd0;
    end else if (rot2_s[1]) begin
      offset_s = 2'd1;
    end else if (rot2_s[2]) begin
      offset_s = 2'd2;
    end else begin
      offset_s = 2'd3;
    end
    gnt_idx_s = ptr_q + offset_s;
    grant_s   = accept_s & (|req_valid) & ~rst;
    if (grant_s) begin
      req_ready = 4'b0001 << gnt_idx_s;
    end else begin
      req_ready = 4'b0000;
    end
    case (gnt_idx_s)
      2'd0:    sample_s = req_data[12:0];
      2'd1:    sample_s = req_data[25:13];
      2'd2:    sample_s = req_data[38:26];
      2'd3:    sample_s = req_data[51:39];
      default: sample_s = req_data[12:0];
    endcase
    cvt_s = fp_convert(sample_s);
  end

  // Next-state for the EMPTY/FULL output stage, pointer and counter.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    out_id_d = out_id_q;
    out_s_d  = out_s_q;
    out_e_d  = out_e_q;
    out_f_d  = out_f_q;
    case (state_q)
      ST_EMPTY: state_d = grant_s ? ST_FULL : ST_EMPTY;
      ST_FULL:  state_d = (out_ready && !grant_s) ? ST_EMPTY : ST_FULL;
      default:  state_d = ST_EMPTY;
    endcase
    if (grant_s) begin
      ptr_d    = gnt_idx_s + 2'd1;
      out_id_d = gnt_idx_s;
      out_s_d  = cvt_s[8];
      out_e_d  = cvt_s[7:5];
      out_f_d  = cvt_s[4:0];
    end else begin
      ptr_d    = ptr_q;
    end
    if (xfer_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // All state registers, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      ptr_q    <= 2'd0;
      out_id_q <= 2'd0;
      out_s_q  <= 1'b0;
      out_e_q  <= 3'd0;
      out_f_q  <= 5'd0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      out_id_q <= out_id_d;
      out_s_q  <= out_s_d;
      out_e_q  <= out_e_d;
      out_f_q  <= out_f_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fpcvt_arb.sv
// Directed bench for fpcvt_arb: conversion vectors, round robin, backpressure and reset.
module tb_fpcvt_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [51:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic        out_s;
  logic [2:0]  out_e;
  logic [4:0]  out_f;
  logic [15:0] conv_count;

  int n_checks;
  int n_errors;

  fpcvt_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_s(out_s), .out_e(out_e), .out_f(out_f),
    .conv_count(conv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request from requester id; checks the grant and the registered result.
  task automatic single(input logic [1:0] id, input logic [12:0] d,
                        input logic es, input logic [2:0] ee, input logic [4:0] ef);
    req_valid = 4'b0001 << id;
    req_data[13*id +: 13] = d;
    #1;
    chk("single_ready", {28'd0, req_ready}, {28'd0, 4'b0001 << id});
    step();
    req_valid = 4'b0000;
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_id", {30'd0, out_id}, {30'd0, id});
    chk("single_s", {31'd0, out_s}, {31'd0, es});
    chk("single_e", {29'd0, out_e}, {29'd0, ee});
    chk("single_f", {27'd0, out_f}, {27'd0, ef});
  endtask

  initial begin
    logic [1:0] g;
    logic [1:0] prev_g;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = 52'd0;
    out_ready = 1'b1;

    // Reset held for two cycles with every requester valid
    step();
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {16'd0, conv_count}, 32'd0);
    step();
    chk("rst_ready2", {28'd0, req_ready}, 32'd0);
    rst = 1'b0;
    req_valid = 4'b0000;

    // Conversion vectors; requester 0 first confirms ptr starts at 0
    single(2'd0, 13'd0,    1'b0, 3'd0, 5'b00000);
    chk("count_first", {16'd0, conv_count}, 32'd0);
    single(2'd2, 13'd422,  1'b0, 3'd4, 5'b11010);
    single(2'd2, 13'h1FF9, 1'b1, 3'd0, 5'b00111);
    single(2'd1, 13'd63,   1'b0, 3'd2, 5'b10000);
    single(2'd3, 13'd4095, 1'b0, 3'd7, 5'b11111);
    single(2'd0, 13'h1000, 1'b1, 3'd7, 5'b11111);
    chk("count_5", {16'd0, conv_count}, 32'd5);
    single(2'd1, 13'd47,   1'b0, 3'd1, 5'b11000);
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_count", {16'd0, conv_count}, 32'd7);

    // Round robin from ptr=2 with all requesters valid; sample i = i+5
    for (int i = 0; i < 4; i++) req_data[13*i +: 13] = 13'(i + 5);
    req_valid = 4'b1111;
    prev_g = 2'd0;
    for (int k = 0; k < 6; k++) begin
      g = 2'(2 + k);
      #1;
      chk("rr_ready", {28'd0, req_ready}, {28'd0, 4'b0001 << g});
      if (k > 0) begin
        chk("rr_valid", {31'd0, out_valid}, 32'd1);
        chk("rr_id", {30'd0, out_id}, {30'd0, prev_g});
        chk("rr_f", {27'd0, out_f}, 32'(prev_g) + 32'd5);
        chk("rr_count", {16'd0, conv_count}, 32'(7 + k - 1));
      end
      prev_g = g;
      step();
    end
    chk("rr_last_id", {30'd0, out_id}, 32'd3);
    chk("rr_last_count", {16'd0, conv_count}, 32'd12);

    // Backpressure: three stalled cycles, output held and nothing granted
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", {28'd0, req_ready}, 32'd0);
      step();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_id", {30'd0, out_id}, 32'd3);
      chk("bp_f", {27'd0, out_f}, 32'd8);
      chk("bp_count", {16'd0, conv_count}, 32'd12);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", {28'd0, req_ready}, 32'b0001);
    step();
    req_valid = 4'b0000;
    chk("bp_resume_id", {30'd0, out_id}, 32'd0);
    chk("bp_resume_f", {27'd0, out_f}, 32'd5);
    chk("bp_resume_count", {16'd0, conv_count}, 32'd13);
    step();
    chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_drain_count", {16'd0, conv_count}, 32'd14);

    // Mid-operation reset while FULL and stalled
    single(2'd1, 13'd20, 1'b0, 3'd0, 5'd20);
    out_ready = 1'b0;
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("mrst_ready", {28'd0, req_ready}, 32'd0);
    step();
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_count", {16'd0, conv_count}, 32'd0);
    chk("mrst_f", {27'd0, out_f}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mrst_ptr_ready", {28'd0, req_ready}, 32'b0001);
    step();
    req_valid = 4'b0000;
    chk("mrst_id", {30'd0, out_id}, 32'd0);
    chk("mrst_new_f", {27'd0, out_f}, 32'd5);
    chk("mrst_new_valid", {31'd0, out_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpcvt_arb.md
# fpcvt_arb

Round-robin arbiter and pipeline controller that shares one 13-bit linear-to-floating-point converter between four requesters. Each requester presents a 13-bit two's-complement sample with a valid/ready handshake. The block grants one requester per cycle, converts the sample to sign/3-bit exponent/5-bit significand form, and holds the result in a registered output stage with its requester ID and a valid/ready handshake. It sits between the sample sources (switch/ADC front ends) and the display/consumer logic.

## Interface
- NREQ, 4, number of requesters; fixed at 4, because the ID width is 2.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  4  bit i set: requester i presents a sample.
- req_data  input  52  requester i sample on bits [13i+12:13i], two's complement.
- req_ready  output  4  one-hot or zero; bit i set: requester i is accepted this cycle.
- out_valid  output  1  output register holds a result.
- out_ready  input  1  consumer takes the result this cycle.
- out_id  output  2  index of the requester that produced the result.
- out_s  output  1  sign.
- out_e  output  3  exponent.
- out_f  output  5  significand.
- conv_count  output  16  number of completed output transfers; saturates at 16'hFFFF.

## Operation
- Accept condition: accept = ~out_valid | out_ready.
- Grant: when accept is true and any req_valid bit is set, the first set bit searched upward from ptr (modulo 4) wins.
  - req_ready is combinational and equals the one-hot winner gated by accept.
  - req_ready is zero when there is no winner.
- ptr register:
  - On a grant to requester g, ptr <= g+1 mod 4.
  - ptr is unchanged when there is no grant.
- Output register load: on a grant it loads the converted winner sample, out_id <= g, and out_valid <= 1.
- Output register clear: on out_valid & out_ready with no grant, out_valid <= 0.
- Simultaneous transfer and grant: the register reloads (back-to-back, no bubble).
- conv_count: increments on every out_valid & out_ready cycle and saturates at 16'hFFFF.
- Conversion, applied to sample D[12:0]:
  - S = D[12].
  - mag = |D| over 13 bits; if mag[12] is set (only for D = 13'h1000), mag = 12'hFFF.
  - If mag < 32: E = 0, F = mag[4:0], round bit = 0.
  - Otherwise, with the leading one at bit p (5..11): E = p-4, F = mag[p:p-4], round bit = mag[p-5].
  - If the round bit is 1, F = F+1.
  - If that increment wraps F from 11111 to 00000: F = 10000 and E = E+1.
  - If E was already 7: saturate to E = 7, F = 11111.
- FSM: two implicit states, EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY on a transfer with no grant.
  - FULL -> FULL on a stall, or on a transfer together with a grant.

## Timing
- Reset values: out_valid=0, out_id=0, out_s=0, out_e=0, out_f=0, conv_count=0, ptr=0. req_ready is 0 while rst is high.
- Latency: sample accepted at edge N (req_ready high in cycle N-1), result valid in the cycle after edge N, i.e. 1 cycle.
- Throughput: one conversion per cycle while out_ready stays high.
- Stall: while out_valid=1 and out_ready=0, out_* are held stable and req_ready=0.
- Requesters may drop req_valid at any time; only same-cycle req_valid & req_ready constitutes a transfer.
- rst asserted mid-operation: the pending result is discarded, registers return to reset values at that edge, and nothing is granted in the rst cycle.

## Test plan
- Reset: hold rst 2 cycles with all req_valid=1 -> req_ready=0000, out_valid=0, conv_count=0; the first grant after release goes to requester 0.
- Single request: req 2 presents 13'd422 with out_ready=1 -> next cycle out_valid=1, out_id=2, S=0, E=4, F=11010; req 2 presents 13'h1FF9 (-7) -> S=1, E=0, F=00111.
- Rounding and saturation:
  - 13'd63 -> E=2, F=10000.
  - 13'd4095 -> E=7, F=11111.
  - 13'h1000 -> S=1, E=7, F=11111.
  - 13'd0 -> S=0, E=0, F=00000.
- Round robin: all four requesters continuously valid, out_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; out_id follows the same order one cycle later with no bubbles; conv_count increments every cycle.
- Backpressure: out_ready=0 for 3 cycles while FULL -> out_* stable and req_ready=0000; set out_ready=1 -> the next grant resumes from ptr and conv_count increments once per transfer.
- Mid-operation reset: assert rst while FULL with out_ready=0 -> the next cycle has out_valid=0 and ptr=0; the stale result never appears.
